// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: return-path owner
// encoding, default word-address width and data width.
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DATA_W     = 32;

    // Who is owed read data in the cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_LOAD = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port (pipeline / loader) arbiter in front of a single-ported data
// memory with 1-cycle synchronous read latency. The pipeline has fixed
// priority. Read data is routed back to whichever port owned the read.
// Optional starvation guard for the loader port: define DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rst,
    // pipeline port
    input  logic              p_req,
    input  logic              p_we,
    input  logic [31:0]       p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    // loader port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              addr_err
);

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("dmem_arbiter: STARVE_MAX must lie in 1..255");
    end

    owner_e            owner_q, owner_d;
    logic              oor_rd_q, oor_rd_d;
    logic [DATA_W-1:0] p_rdata_q, d_rdata_q;
    logic              starve_force;
    logic [31:0]       sel_addr;
    logic              sel_we;
    logic              granted;
    logic              oor;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    logic [7:0] starve_cnt_q, starve_cnt_d;

    // Count consecutive denied loader cycles; clear on grant or idle loader.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!d_req || d_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != 8'hFF) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end

    assign starve_force = d_req && (starve_cnt_q >= STARVE_LIM);
`else
    assign starve_force = 1'b0;
`endif

    // Combinational grant: pipeline first unless the loader is overdue.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (d_req && (!p_req || starve_force)) d_gnt = 1'b1;
            else if (p_req)                        p_gnt = 1'b1;
        end
    end

    assign p_stall = p_req & ~p_gnt;

    // Memory-side mux: the loader drives only when it holds the grant.
    always_comb begin
        sel_addr = p_addr;
        sel_we   = p_we;
        mem_wd   = p_wdata;
        if (d_gnt) begin
            sel_addr = d_addr;
            sel_we   = d_we;
            mem_wd   = d_wdata;
        end
    end

    assign granted  = p_gnt | d_gnt;
    assign oor      = granted && (sel_addr[31:ADDR_W] != '0);
    assign mem_addr = sel_addr[ADDR_W-1:0];
    assign mem_we   = granted && sel_we && !oor;
    assign addr_err = oor;

    // Owner state register, rewritten every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            oor_rd_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            oor_rd_q <= oor_rd_d;
        end
    end

    // Next owner: the winner of a granted read, otherwise nobody.
    always_comb begin
        owner_d  = OWN_NONE;
        oor_rd_d = 1'b0;
        if (p_gnt && !p_we) begin
            owner_d  = OWN_PIPE;
            oor_rd_d = oor;
        end else if (d_gnt && !d_we) begin
            owner_d  = OWN_LOAD;
            oor_rd_d = oor;
        end
    end

    // Return routing: the owner sees memory data (zero if out of range),
    // the other port keeps presenting its last returned word.
    always_comb begin
        p_rvalid = (owner_q == OWN_PIPE);
        d_rvalid = (owner_q == OWN_LOAD);
        p_rdata  = p_rdata_q;
        d_rdata  = d_rdata_q;
        if (p_rvalid) p_rdata = oor_rd_q ? '0 : mem_rd;
        if (d_rvalid) d_rdata = oor_rd_q ? '0 : mem_rd;
    end

    // Hold registers for the read-data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            p_rdata_q <= p_rdata;
            d_rdata_q <= d_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps followed by random
// traffic, all compared against a behavioural model (priority rule, a
// word array for memory contents, expected return per port).
module tb_dmem_arbiter;

    localparam int AW   = 10;
    localparam int SMAX = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, d_req, d_we;
    logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
    logic        p_gnt, p_stall, p_rvalid, d_gnt, d_rvalid;
    logic [31:0] p_rdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wd, mem_rd;
    logic        mem_we, addr_err;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd), .addr_err(addr_err)
    );

    // Synchronous single-port RAM, read latency 1.
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wd;
        mem_rd <= ram[mem_addr];
    end

    // Reference model state
    logic [31:0] ref_mem [0:15];
    int          starve;
    logic        pend_p, pend_d;
    logic [31:0] pend_pdata, pend_ddata, last_p, last_d;
    logic        last_pg, last_dg;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the current inputs; entered and left 1 time unit
    // after a rising edge.
    task automatic step();
        logic        force_ld, eg_p, eg_d, granted, out_rng, w_we;
        logic [31:0] w_addr, w_wd, rdval;
        #1;
        chk("p_rvalid", {31'd0, p_rvalid}, {31'd0, pend_p});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, pend_d});
        if (pend_p) last_p = pend_pdata;
        if (pend_d) last_d = pend_ddata;
        chk("p_rdata", p_rdata, last_p);
        chk("d_rdata", d_rdata, last_d);

        force_ld = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
        force_ld = d_req && (starve >= SMAX);
`endif
        eg_d    = d_req && (!p_req || force_ld);
        eg_p    = p_req && !eg_d;
        w_addr  = eg_d ? d_addr  : p_addr;
        w_we    = eg_d ? d_we    : p_we;
        w_wd    = eg_d ? d_wdata : p_wdata;
        granted = eg_p || eg_d;
        out_rng = granted && (w_addr >= 32'(1 << AW));

        chk("p_gnt",    {31'd0, p_gnt},    {31'd0, eg_p});
        chk("d_gnt",    {31'd0, d_gnt},    {31'd0, eg_d});
        chk("p_stall",  {31'd0, p_stall},  {31'd0, p_req && !eg_p});
        chk("mem_we",   {31'd0, mem_we},   {31'd0, granted && w_we && !out_rng});
        chk("addr_err", {31'd0, addr_err}, {31'd0, out_rng});
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, w_addr[AW-1:0]});
        if (granted && w_we) chk("mem_wd", mem_wd, w_wd);

        rdval      = out_rng ? 32'h0 : ref_mem[w_addr[3:0]];
        pend_p     = eg_p && !p_we;
        pend_d     = eg_d && !d_we;
        pend_pdata = rdval;
        pend_ddata = rdval;
        if (granted && w_we && !out_rng) ref_mem[w_addr[3:0]] = w_wd;
        starve  = (d_req && !eg_d) ? starve + 1 : 0;
        last_pg = eg_p;
        last_dg = eg_d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Apply reset for one edge with whatever requests are currently driven.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_p_gnt",  {31'd0, p_gnt},  32'd0);
        chk("rst_d_gnt",  {31'd0, d_gnt},  32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend_p = 1'b0; pend_d = 1'b0;
        last_p = 32'd0; last_d = 32'd0;
        starve = 0;
        chk("rst_p_rvalid", {31'd0, p_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst_p_rdata",  p_rdata, 32'd0);
        chk("rst_d_rdata",  d_rdata, 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 11))
            0:       return 32'h400 + 32'($urandom_range(0, 15));
            1:       return 32'hFFFF_0000 | 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        logic        rp, rd;
        rst = 1'b1;
        p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        starve = 0; pend_p = 0; pend_d = 0; last_p = 0; last_d = 0;
        last_pg = 0; last_dg = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Preload every modelled word through the pipeline port.
        for (int i = 0; i < 16; i++)
            drive(1, 1, 32'(i), 32'hA500_0000 + 32'(i * 17), 0, 0, 0, 0);

        // Pipeline-only write then read-back.
        drive(1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(1, 0, 32'd5, 32'd0, 0, 0, 0, 0);
        idle();

        // Alternating owners on consecutive cycles.
        drive(1, 0, 32'd1, 32'd0, 0, 0, 0, 0);
        drive(0, 0, 32'd0, 32'd0, 1, 0, 32'd2, 32'd0);
        idle();

        // Out-of-range write must not alias onto word 0; read returns zero.
        drive(0, 0, 32'd0, 32'd0, 1, 1, 32'h400, 32'h1234_5678);
        drive(0, 0, 32'd0, 32'd0, 1, 0, 32'h400, 32'd0);
        drive(0, 0, 32'd0, 32'd0, 1, 0, 32'd0, 32'd0);
        idle();

        // Same-address collision: write wins first, loader read follows.
        drive(1, 1, 32'd7, 32'h7777_7777, 1, 0, 32'd7, 32'd0);
        drive(0, 0, 32'd0, 32'd0, 1, 0, 32'd7, 32'd0);
        idle();

        // Sustained contention with a waiting loader write.
        rd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 32'(i % 16), 32'd0, rd, 1, 32'd9, 32'h0000_0099);
            if (last_dg) rd = 1'b0;
        end
        idle();

        // Reset asserted in the grant cycle of a loader read.
        drive(0, 0, 32'd0, 32'd0, 1, 0, 32'd3, 32'd0);
        p_req = 0; d_req = 1; d_we = 0; d_addr = 32'd3;
        do_reset();
        idle();

        // Random traffic; each requester holds its request until granted.
        rp = 1'b0; rd = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!rp) begin
                rp      = ($urandom_range(0, 9) < 6);
                p_we    = $urandom_range(0, 1) == 1;
                p_addr  = rnd_addr();
                p_wdata = $urandom;
            end
            if (!rd) begin
                rd      = ($urandom_range(0, 1) == 1);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = rnd_addr();
                d_wdata = $urandom;
            end
            p_req = rp;
            d_req = rd;
            step();
            if (last_pg) rp = 1'b0;
            if (last_dg) rd = 1'b0;
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
